// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
//
// Runs a configurable number of rounds over a chain of handshaked datapath
// stages. In each round every enabled stage gets a one-cycle start pulse and
// the sequencer waits for that stage's completion strobe before moving on.
// Disabled stages are skipped at one cycle each.
//
// Optional feature macro: ROUND_SEQ_TIMEOUT_EN
//   When defined, a per-stage watchdog aborts a stalled round after
//   TIMEOUT_CYCLES wait cycles, raising error_o and ending the run.
//   When undefined, error_o is tied low and stages may stall indefinitely.
//
// Ports
//   clk_i           clock, all state changes on the rising edge
//   rst_ni          asynchronous active-low reset
//   start_i         launch request, only looked at while idle
//   num_rounds_i    round count, captured when a launch is accepted
//   stage_mask_i    per-stage enable, captured when a launch is accepted
//   stage_start_o   one-hot, one-cycle start pulse to a stage
//   stage_finish_i  completion strobe from each stage
//   iteration_o     index of the current (or last completed) round
//   busy_o          high whenever the sequencer is not idle
//   finish_o        one-cycle pulse when a run ends
//   error_o         watchdog fault flag
// -----------------------------------------------------------------------------
module round_sequencer #(
    parameter int NUM_STAGES     = 5,
    parameter int ROUND_W        = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ROUND_W-1:0]    num_rounds_i,
    input  logic [NUM_STAGES-1:0] stage_mask_i,
    output logic [NUM_STAGES-1:0] stage_start_o,
    input  logic [NUM_STAGES-1:0] stage_finish_i,
    output logic [ROUND_W-1:0]    iteration_o,
    output logic                  busy_o,
    output logic                  finish_o,
    output logic                  error_o
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_STG_START,
        S_STG_WAIT,
        S_IT_CHECK,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ROUND_W-1:0]      iter_q, iter_d;
    logic [ROUND_W-1:0]      rounds_q, rounds_d;
    logic [NUM_STAGES-1:0]   mask_q, mask_d;
    logic                    idx_last;
    logic                    last_round;

`ifdef ROUND_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            error_q, error_d;
`endif

    assign idx_last   = (idx_q == LAST_IDX);
    // Only reached with a non-zero round count, so the subtraction never wraps.
    assign last_round = (iter_q == ROUND_W'(rounds_q - ROUND_W'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            iter_q   <= '0;
            rounds_q <= '0;
            mask_q   <= '0;
`ifdef ROUND_SEQ_TIMEOUT_EN
            wdog_q   <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            iter_q   <= iter_d;
            rounds_q <= rounds_d;
            mask_q   <= mask_d;
`ifdef ROUND_SEQ_TIMEOUT_EN
            wdog_q   <= wdog_d;
            error_q  <= error_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        iter_d   = iter_q;
        rounds_d = rounds_q;
        mask_d   = mask_q;
`ifdef ROUND_SEQ_TIMEOUT_EN
        wdog_d   = wdog_q;
        error_d  = error_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rounds_d = num_rounds_i;
                    mask_d   = stage_mask_i;
                    state_d  = S_INIT;
                end
            end
            S_INIT: begin
                iter_d = '0;
                idx_d  = '0;
`ifdef ROUND_SEQ_TIMEOUT_EN
                error_d = 1'b0;
`endif
                state_d = (rounds_q == '0) ? S_DONE : S_STG_START;
            end
            S_STG_START: begin
                // Finish strobes are never looked at here, so a stage
                // answering in its own start cycle is not accepted.
                if (mask_q[idx_q]) begin
                    state_d = S_STG_WAIT;
`ifdef ROUND_SEQ_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end else if (idx_last) begin
                    state_d = S_IT_CHECK;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_STG_WAIT: begin
                if (stage_finish_i[idx_q]) begin
                    if (idx_last) begin
                        state_d = S_IT_CHECK;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_STG_START;
                    end
`ifdef ROUND_SEQ_TIMEOUT_EN
                end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the last allowed wait cycle; abandon the run.
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
`endif
                end
            end
            S_IT_CHECK: begin
                if (last_round) begin
                    state_d = S_DONE;
                end else begin
                    iter_d  = iter_q + ROUND_W'(1);
                    idx_d   = '0;
                    state_d = S_STG_START;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All outputs decode straight from registered state.
    always_comb begin
        stage_start_o = '0;
        if (state_q == S_STG_START && mask_q[idx_q]) begin
            stage_start_o[idx_q] = 1'b1;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign finish_o    = (state_q == S_DONE);
    assign iteration_o = iter_q;

`ifdef ROUND_SEQ_TIMEOUT_EN
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_round_sequencer
//
// Directed testbench for round_sequencer. A stage responder answers each
// start pulse with a finish strobe a programmable number of cycles later,
// and a monitor logs every pulse and finish so each scenario task can
// compare the logs against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_round_sequencer;

    localparam int NS = 5;
    localparam int RW = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstN;
    logic          start;
    logic [RW-1:0] numRounds;
    logic [NS-1:0] stageMask;
    logic [NS-1:0] stageStart;
    logic [NS-1:0] stageFinish;
    logic [RW-1:0] iteration;
    logic          busy;
    logic          finish;
    logic          error;

    int nCompared = 0;
    int nMismatch = 0;

    // Monitor logs
    int   cyc = 0;
    int   pulseStage[$];
    int   pulseIter[$];
    int   pulseCyc[$];
    int   finishCount = 0;
    int   finishCycle = 0;
    logic finishErr = 1'b0;
    int   multiHot = 0;
    int   acceptCyc = 0;

    // Responder controls
    logic          respEnable = 1'b0;
    int            respDelay = 3;
    logic [NS-1:0] respIgnore = '0;
    logic [NS-1:0] strayBits = '0;

    always #5 clk = ~clk;

    round_sequencer #(
        .NUM_STAGES    (NS),
        .ROUND_W       (RW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .start_i       (start),
        .num_rounds_i  (numRounds),
        .stage_mask_i  (stageMask),
        .stage_start_o (stageStart),
        .stage_finish_i(stageFinish),
        .iteration_o   (iteration),
        .busy_o        (busy),
        .finish_o      (finish),
        .error_o       (error)
    );

    // Monitor: samples just after each rising edge and logs pulses/finishes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (stageStart != '0) begin
                if ($countones(stageStart) != 1) multiHot++;
                for (int i = 0; i < NS; i++) begin
                    if (stageStart[i]) begin
                        pulseStage.push_back(i);
                        pulseIter.push_back(int'(iteration));
                        pulseCyc.push_back(cyc);
                    end
                end
            end
            if (finish) begin
                finishCount++;
                finishCycle = cyc;
                finishErr   = error;
            end
        end
    end

    // Stage responder: delay 0 answers inside the pulse cycle only.
    initial begin
        int            cnt;
        logic [NS-1:0] pend;
        logic [NS-1:0] fin;
        cnt = 0;
        pend = '0;
        stageFinish = '0;
        forever begin
            @(negedge clk);
            fin = '0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) fin = pend;
            end
            if (respEnable && stageStart != '0) begin
                if (respDelay == 0) begin
                    fin = fin | (stageStart & ~respIgnore);
                end else begin
                    pend = stageStart & ~respIgnore;
                    cnt  = respDelay;
                end
            end
            stageFinish = fin | strayBits;
        end
    end

    task automatic clearLogs();
        pulseStage.delete();
        pulseIter.delete();
        pulseCyc.delete();
        finishCount = 0;
        multiHot    = 0;
    endtask

    task automatic applyStimulus(input int rounds, input logic [NS-1:0] mask);
        @(negedge clk);
        numRounds = RW'(rounds);
        stageMask = mask;
        start     = 1'b1;
        @(posedge clk);
        #2;
        acceptCyc = cyc;
        start     = 1'b0;
    endtask

    task automatic waitFinish(input int budget, output bit timedOut);
        timedOut = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (finishCount > 0) begin
                timedOut = 1'b0;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN      = 1'b0;
        start     = 1'b0;
        numRounds = '0;
        stageMask = '0;
        #3;
        nCompared++; if (busy !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        nCompared++; if (finish !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_finish: got %b expected 0", finish); end
        nCompared++; if (stageStart !== '0) begin nMismatch++; $display("[TB] FAIL reset_stage_start: got %b expected 0", stageStart); end
        nCompared++; if (iteration !== '0) begin nMismatch++; $display("[TB] FAIL reset_iteration: got %0d expected 0", iteration); end
        nCompared++; if (error !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_error: got %b expected 0", error); end
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_full_run();
        bit timedOut;
        int orderErr;
        clearLogs();
        respEnable = 1'b1;
        respDelay  = 3;
        applyStimulus(24, 5'b11111);
        waitFinish(2000, timedOut);
        orderErr = 0;
        for (int j = 0; j < pulseStage.size(); j++) begin
            if (pulseStage[j] != j % 5 || pulseIter[j] != j / 5) orderErr++;
        end
        nCompared++; if (timedOut) begin nMismatch++; $display("[TB] FAIL full_timeout: got no finish expected finish"); end
        nCompared++; if (pulseStage.size() != 120) begin nMismatch++; $display("[TB] FAIL full_pulse_count: got %0d expected 120", pulseStage.size()); end
        nCompared++; if (orderErr != 0) begin nMismatch++; $display("[TB] FAIL full_order: got %0d bad pulses expected 0", orderErr); end
        nCompared++; if (multiHot != 0) begin nMismatch++; $display("[TB] FAIL full_onehot: got %0d multi-hot cycles expected 0", multiHot); end
        nCompared++; if (pulseCyc.size() == 0 || pulseCyc[0] != acceptCyc + 1) begin nMismatch++; $display("[TB] FAIL full_first_pulse: got %0d expected %0d", (pulseCyc.size() == 0) ? -1 : pulseCyc[0], acceptCyc + 1); end
        nCompared++; if (finishCount != 1) begin nMismatch++; $display("[TB] FAIL full_finish_count: got %0d expected 1", finishCount); end
        nCompared++; if (finishCycle != acceptCyc + 505) begin nMismatch++; $display("[TB] FAIL full_finish_cycle: got %0d expected %0d", finishCycle, acceptCyc + 505); end
        nCompared++; if (iteration !== RW'(23)) begin nMismatch++; $display("[TB] FAIL full_final_iter: got %0d expected 23", iteration); end
        nCompared++; if (busy !== 1'b0) begin nMismatch++; $display("[TB] FAIL full_busy_after: got %b expected 0", busy); end
        nCompared++; if (error !== 1'b0) begin nMismatch++; $display("[TB] FAIL full_error: got %b expected 0", error); end
    endtask

    task automatic test_zero_rounds();
        bit timedOut;
        clearLogs();
        applyStimulus(0, 5'b11111);
        waitFinish(20, timedOut);
        nCompared++; if (timedOut) begin nMismatch++; $display("[TB] FAIL zero_timeout: got no finish expected finish"); end
        nCompared++; if (finishCycle != acceptCyc + 1) begin nMismatch++; $display("[TB] FAIL zero_finish_cycle: got %0d expected %0d", finishCycle, acceptCyc + 1); end
        nCompared++; if (pulseStage.size() != 0) begin nMismatch++; $display("[TB] FAIL zero_pulses: got %0d expected 0", pulseStage.size()); end
        nCompared++; if (iteration !== '0) begin nMismatch++; $display("[TB] FAIL zero_iter: got %0d expected 0", iteration); end
    endtask

    task automatic test_sparse_mask();
        bit timedOut;
        int expStage[6] = '{0, 2, 4, 0, 2, 4};
        int expIter[6]  = '{0, 0, 0, 1, 1, 1};
        int orderErr;
        clearLogs();
        #2;
        strayBits = 5'b01010;
        applyStimulus(2, 5'b10101);
        waitFinish(200, timedOut);
        #2;
        strayBits = '0;
        orderErr = 0;
        for (int j = 0; j < 6 && j < pulseStage.size(); j++) begin
            if (pulseStage[j] != expStage[j] || pulseIter[j] != expIter[j]) orderErr++;
        end
        nCompared++; if (timedOut) begin nMismatch++; $display("[TB] FAIL sparse_timeout: got no finish expected finish"); end
        nCompared++; if (pulseStage.size() != 6) begin nMismatch++; $display("[TB] FAIL sparse_pulse_count: got %0d expected 6", pulseStage.size()); end
        nCompared++; if (orderErr != 0) begin nMismatch++; $display("[TB] FAIL sparse_order: got %0d bad pulses expected 0", orderErr); end
        nCompared++; if (finishCycle != acceptCyc + 31) begin nMismatch++; $display("[TB] FAIL sparse_finish_cycle: got %0d expected %0d", finishCycle, acceptCyc + 31); end
        nCompared++; if (iteration !== RW'(1)) begin nMismatch++; $display("[TB] FAIL sparse_final_iter: got %0d expected 1", iteration); end
    endtask

    task automatic test_zero_mask();
        bit timedOut;
        clearLogs();
        applyStimulus(2, 5'b00000);
        waitFinish(100, timedOut);
        nCompared++; if (timedOut) begin nMismatch++; $display("[TB] FAIL zmask_timeout: got no finish expected finish"); end
        nCompared++; if (pulseStage.size() != 0) begin nMismatch++; $display("[TB] FAIL zmask_pulses: got %0d expected 0", pulseStage.size()); end
        nCompared++; if (finishCycle != acceptCyc + 13) begin nMismatch++; $display("[TB] FAIL zmask_finish_cycle: got %0d expected %0d", finishCycle, acceptCyc + 13); end
    endtask

    task automatic test_max_rounds();
        bit timedOut;
        clearLogs();
        applyStimulus(31, 5'b00000);
        waitFinish(400, timedOut);
        nCompared++; if (timedOut) begin nMismatch++; $display("[TB] FAIL max_timeout: got no finish expected finish"); end
        nCompared++; if (finishCycle != acceptCyc + 187) begin nMismatch++; $display("[TB] FAIL max_finish_cycle: got %0d expected %0d", finishCycle, acceptCyc + 187); end
        nCompared++; if (iteration !== RW'(30)) begin nMismatch++; $display("[TB] FAIL max_final_iter: got %0d expected 30", iteration); end
        nCompared++; if (finishCount != 1) begin nMismatch++; $display("[TB] FAIL max_finish_count: got %0d expected 1", finishCount); end
    endtask

    task automatic test_same_cycle_finish();
        bit timedOut;
        clearLogs();
        respDelay = 0;
        applyStimulus(1, 5'b00001);
        repeat (10) @(negedge clk);
        nCompared++; if (busy !== 1'b1) begin nMismatch++; $display("[TB] FAIL early_busy: got %b expected 1", busy); end
        nCompared++; if (finishCount != 0) begin nMismatch++; $display("[TB] FAIL early_finish: got %0d expected 0", finishCount); end
        @(posedge clk);
        #2;
        strayBits = 5'b00001;
        @(posedge clk);
        #2;
        strayBits = '0;
        waitFinish(20, timedOut);
        respDelay = 3;
        nCompared++; if (timedOut || finishCount != 1) begin nMismatch++; $display("[TB] FAIL late_finish: got %0d finishes expected 1", finishCount); end
    endtask

    task automatic test_back_to_back();
        bit timedOut;
        int orderErr;
        clearLogs();
        applyStimulus(3, 5'b00011);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            numRounds = RW'(7);
            stageMask = 5'b11111;
            start     = (i % 2 == 0);
        end
        start = 1'b0;
        waitFinish(200, timedOut);
        orderErr = 0;
        for (int j = 0; j < pulseStage.size(); j++) begin
            if (pulseStage[j] != j % 2 || pulseIter[j] != j / 2) orderErr++;
        end
        nCompared++; if (timedOut) begin nMismatch++; $display("[TB] FAIL busy_start_timeout: got no finish expected finish"); end
        nCompared++; if (pulseStage.size() != 6) begin nMismatch++; $display("[TB] FAIL busy_start_pulses: got %0d expected 6", pulseStage.size()); end
        nCompared++; if (orderErr != 0) begin nMismatch++; $display("[TB] FAIL busy_start_order: got %0d bad pulses expected 0", orderErr); end
        nCompared++; if (iteration !== RW'(2)) begin nMismatch++; $display("[TB] FAIL busy_start_iter: got %0d expected 2", iteration); end
        nCompared++; if (finishCount != 1) begin nMismatch++; $display("[TB] FAIL busy_start_finish: got %0d expected 1", finishCount); end
    endtask

    task automatic test_reset_mid_run();
        bit timedOut;
        bit reached;
        clearLogs();
        applyStimulus(5, 5'b11111);
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pulseIter.size() > 0 && pulseIter[$] == 3) begin
                reached = 1'b1;
                break;
            end
        end
        nCompared++; if (!reached) begin nMismatch++; $display("[TB] FAIL midreset_reach: got no round-3 pulse expected one"); end
        @(negedge clk);
        rstN = 1'b0;
        #1;
        nCompared++; if (busy !== 1'b0) begin nMismatch++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        nCompared++; if (iteration !== '0) begin nMismatch++; $display("[TB] FAIL midreset_iter: got %0d expected 0", iteration); end
        repeat (4) @(negedge clk);
        nCompared++; if (finishCount != 0) begin nMismatch++; $display("[TB] FAIL midreset_finish: got %0d expected 0", finishCount); end
        rstN = 1'b1;
        clearLogs();
        applyStimulus(1, 5'b11111);
        waitFinish(200, timedOut);
        nCompared++; if (timedOut || pulseStage.size() != 5) begin nMismatch++; $display("[TB] FAIL midreset_rerun_pulses: got %0d expected 5", pulseStage.size()); end
        nCompared++; if (finishCount != 1) begin nMismatch++; $display("[TB] FAIL midreset_rerun_finish: got %0d expected 1", finishCount); end
    endtask

    task automatic test_timeout();
        bit timedOut;
        clearLogs();
        respIgnore = 5'b00100;
        applyStimulus(1, 5'b11111);
`ifdef ROUND_SEQ_TIMEOUT_EN
        waitFinish(200, timedOut);
        nCompared++; if (timedOut) begin nMismatch++; $display("[TB] FAIL wd_timeout: got no finish expected finish"); end
        nCompared++; if (pulseStage.size() != 3) begin nMismatch++; $display("[TB] FAIL wd_pulses: got %0d expected 3", pulseStage.size()); end
        nCompared++; if (pulseCyc.size() < 3 || finishCycle != pulseCyc[2] + 17) begin nMismatch++; $display("[TB] FAIL wd_finish_cycle: got %0d expected stage-2 pulse + 17", finishCycle); end
        nCompared++; if (finishErr !== 1'b1) begin nMismatch++; $display("[TB] FAIL wd_error_at_finish: got %b expected 1", finishErr); end
        nCompared++; if (error !== 1'b1 || busy !== 1'b0) begin nMismatch++; $display("[TB] FAIL wd_error_held: got error %b busy %b expected 1 0", error, busy); end
        respIgnore = '0;
        clearLogs();
        applyStimulus(0, 5'b11111);
        waitFinish(20, timedOut);
        nCompared++; if (error !== 1'b0) begin nMismatch++; $display("[TB] FAIL wd_error_cleared: got %b expected 0", error); end
`else
        timedOut = 1'b0;
        repeat (100) @(negedge clk);
        nCompared++; if (busy !== 1'b1) begin nMismatch++; $display("[TB] FAIL nowd_busy: got %b expected 1", busy); end
        nCompared++; if (error !== 1'b0) begin nMismatch++; $display("[TB] FAIL nowd_error: got %b expected 0", error); end
        nCompared++; if (finishCount != 0 || timedOut) begin nMismatch++; $display("[TB] FAIL nowd_finish: got %0d expected 0", finishCount); end
        nCompared++; if (pulseStage.size() != 3) begin nMismatch++; $display("[TB] FAIL nowd_pulses: got %0d expected 3", pulseStage.size()); end
        respIgnore = '0;
        doReset();
`endif
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_zero_rounds();
        test_sparse_mask();
        test_zero_mask();
        test_max_rounds();
        test_same_cycle_finish();
        test_back_to_back();
        test_reset_mid_run();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
